// File: rtl/seg_scan_mux_if.sv
// Bus between a display-value producer and the seven-segment digit scanner.
// The scanner side is the slave: it consumes the value/enables and drives the anodes.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_tick;

  modport master (
    output value_in, load, digit_en,
    input  nibble, digit_sel, frame_tick
  );

  modport slave (
    input  value_in, load, digit_en,
    output nibble, digit_sel, frame_tick
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode seven-segment scanner: SHOW/GAP slots per digit,
// value updates committed only at frame start so a frame never mixes old and new digits.
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int SHOW_CYCLES = 50000,
  parameter int GAP_CYCLES  = 500
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_mux_if.slave bus
);

  localparam int CNT_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_GAP  = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]     shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0]     active_q, active_d;
  logic                        pending_q, pending_d;
  logic [3:0]                  nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0]       digit_sel_q, digit_sel_d;
  logic                        frame_tick_q, frame_tick_d;
  logic                        commit;
  logic [NUM_DIGITS-1:0][3:0]  src;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + CW'(1);
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    nibble_d     = nibble_q;
    digit_sel_d  = digit_sel_q;
    frame_tick_d = 1'b0;
    commit       = 1'b0;
    src          = active_q;

    if (state_q == ST_GAP) begin
      if (cnt_q == GAP_LAST) begin
        state_d = ST_SHOW;
        cnt_d   = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        // Commit on entry to digit 0; the digit shown on this edge already uses it.
        commit  = (idx_d == '0) && pending_q;
        if (commit) begin
          active_d = shadow_q;
          src      = shadow_q;
        end
        nibble_d = src[idx_d];
        for (int d = 0; d < NUM_DIGITS; d++)
          digit_sel_d[d] = !((idx_d == IW'(d)) && bus.digit_en[d]);
      end
    end else begin
      if (cnt_q == SHOW_LAST) begin
        state_d      = ST_GAP;
        cnt_d        = '0;
        digit_sel_d  = '1;
        frame_tick_d = (idx_q == IDX_LAST);
      end else begin
        // A falling enable blanks the anode at once; a rising one waits for the next slot.
        digit_sel_d = digit_sel_q | ~bus.digit_en;
      end
    end

    if (bus.load) begin
      shadow_d  = bus.value_in;
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_GAP;
      idx_q        <= IDX_LAST;
      cnt_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      nibble_q     <= '0;
      digit_sel_q  <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      nibble_q     <= nibble_d;
      digit_sel_q  <= digit_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.nibble     = nibble_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: directed scenarios plus a random load/enable run, all
// checked against a slot/frame-position reference model.
module tb_seg_scan_mux;
  localparam int N     = 4;
  localparam int S     = 4;
  localparam int G     = 2;
  localparam int SLOT  = S + G;
  localparam int FRAME = N * SLOT;

  logic clk = 1'b0;
  logic rst;

  seg_scan_mux_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_mux #(.NUM_DIGITS(N), .SHOW_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: position in the frame derived from edges since reset release.
  int             e;
  int             cur_d, cur_q;
  logic [4*N-1:0] m_shadow, m_active;
  logic           m_pending, m_lit;
  logic [N-1:0]   exp_sel;
  logic [3:0]     exp_nib;
  logic           exp_tick;

  task automatic step();
    logic           r, ld;
    logic [4*N-1:0] v;
    logic [N-1:0]   en;
    int             p;
    r = rst; ld = bus.load; v = bus.value_in; en = bus.digit_en;
    @(posedge clk); #1;
    if (r) begin
      e = 0; m_shadow = '0; m_active = '0; m_pending = 1'b0; m_lit = 1'b0;
      exp_sel = '1; exp_nib = '0; exp_tick = 1'b0; cur_d = -1; cur_q = -1;
      return;
    end
    e++;
    exp_tick = 1'b0;
    if (e < G) begin
      exp_sel = '1; cur_d = -1; cur_q = -1;
    end else begin
      p = (e - G) % FRAME; cur_d = p / SLOT; cur_q = p % SLOT;
      if (cur_q == 0) begin
        if (cur_d == 0 && m_pending) begin
          m_active  = m_shadow;
          m_pending = 1'b0;
        end
        m_lit   = en[cur_d];
        exp_nib = m_active[4*cur_d +: 4];
      end else if (cur_q < S) begin
        m_lit = m_lit & en[cur_d];
      end
      exp_sel  = (cur_q < S && m_lit) ? ~(N'(1) << cur_d) : '1;
      exp_tick = (cur_q == S && cur_d == N - 1);
    end
    if (ld) begin
      m_shadow  = v;
      m_pending = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.load = 1'b0; bus.value_in = '0; bus.digit_en = '1;
    step(); step();
    total++;
    if (bus.digit_sel !== 4'b1111) $display("FAIL reset_sel: got %b want 1111", bus.digit_sel); else passed++;
    total++;
    if (bus.nibble !== 4'h0) $display("FAIL reset_nib: got %h want 0", bus.nibble); else passed++;
    total++;
    if (bus.frame_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", bus.frame_tick); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_scan();
    int ticks = 0;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      step();
      if (bus.frame_tick === 1'b1) ticks++;
      total++;
      if ({bus.digit_sel, bus.nibble, bus.frame_tick} !== {exp_sel, exp_nib, exp_tick})
        $display("FAIL scan e=%0d: got %b/%h/%b want %b/%h/%b", e, bus.digit_sel, bus.nibble,
                 bus.frame_tick, exp_sel, exp_nib, exp_tick);
      else passed++;
    end
    total++;
    if (ticks != 2) $display("FAIL scan_tick_count: got %0d want 2", ticks); else passed++;
  endtask

  task automatic test_load_midframe();
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      bus.load = (i == 9); bus.value_in = 16'hA5C3;
      step();
      bus.load = 1'b0;
      total++;
      if ({bus.digit_sel, bus.nibble, bus.frame_tick} !== {exp_sel, exp_nib, exp_tick})
        $display("FAIL load_mid e=%0d: got %b/%h/%b want %b/%h/%b", e, bus.digit_sel, bus.nibble,
                 bus.frame_tick, exp_sel, exp_nib, exp_tick);
      else passed++;
    end
    total++;
    if (m_active !== 16'hA5C3) $display("FAIL load_mid_model: got %h want a5c3", m_active); else passed++;
  endtask

  task automatic test_commit_collision();
    int guard = 0;
    bus.load = 1'b1; bus.value_in = 16'h5A5A;
    step();
    bus.load = 1'b0;
    while (((e + 1 - G) % FRAME) != 0 && guard < FRAME + 1) begin
      step(); guard++;
    end
    bus.load = 1'b1; bus.value_in = 16'h1234;
    step();
    bus.load = 1'b0;
    total++;
    if ({bus.digit_sel, bus.nibble} !== {4'b1110, 4'hA})
      $display("FAIL collide_commit: got %b/%h want 1110/a", bus.digit_sel, bus.nibble);
    else passed++;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      total++;
      if ({bus.digit_sel, bus.nibble, bus.frame_tick} !== {exp_sel, exp_nib, exp_tick})
        $display("FAIL collide e=%0d: got %b/%h/%b want %b/%h/%b", e, bus.digit_sel, bus.nibble,
                 bus.frame_tick, exp_sel, exp_nib, exp_tick);
      else passed++;
    end
  endtask

  task automatic test_digit_en();
    int ticks = 0;
    int guard = 0;
    bus.digit_en = 4'b1011;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (bus.frame_tick === 1'b1) ticks++;
      total++;
      if ({bus.digit_sel, bus.nibble, bus.frame_tick} !== {exp_sel, exp_nib, exp_tick})
        $display("FAIL digit_en e=%0d: got %b/%h/%b want %b/%h/%b", e, bus.digit_sel, bus.nibble,
                 bus.frame_tick, exp_sel, exp_nib, exp_tick);
      else passed++;
    end
    total++;
    if (ticks != 2) $display("FAIL digit_en_ticks: got %0d want 2", ticks); else passed++;
    bus.digit_en = 4'hF;
    while (!(cur_d == 0 && cur_q == 1) && guard < FRAME + 2) begin
      step(); guard++;
    end
    bus.digit_en = 4'b1110;
    step();
    bus.digit_en = 4'hF;
    total++;
    if (bus.digit_sel !== 4'b1111) $display("FAIL en_fall: got %b want 1111", bus.digit_sel); else passed++;
    for (int i = 0; i < SLOT; i++) begin
      step();
      total++;
      if ({bus.digit_sel, bus.nibble, bus.frame_tick} !== {exp_sel, exp_nib, exp_tick})
        $display("FAIL en_rise e=%0d: got %b/%h/%b want %b/%h/%b", e, bus.digit_sel, bus.nibble,
                 bus.frame_tick, exp_sel, exp_nib, exp_tick);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    bus.load = 1'b1; bus.value_in = 16'hBEEF;
    step();
    bus.load = 1'b0;
    while (!(cur_d == 2 && cur_q == 1) && guard < FRAME + 2) begin
      step(); guard++;
    end
    rst = 1'b1; bus.load = 1'b1; bus.value_in = 16'h7777;
    step();
    rst = 1'b0; bus.load = 1'b0;
    total++;
    if ({bus.digit_sel, bus.nibble, bus.frame_tick} !== {4'b1111, 4'h0, 1'b0})
      $display("FAIL rst_mid: got %b/%h/%b want 1111/0/0", bus.digit_sel, bus.nibble, bus.frame_tick);
    else passed++;
    for (int i = 0; i < G; i++) step();
    total++;
    if ({bus.digit_sel, bus.nibble} !== {4'b1110, 4'h0})
      $display("FAIL rst_restart: got %b/%h want 1110/0", bus.digit_sel, bus.nibble);
    else passed++;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      total++;
      if ({bus.digit_sel, bus.nibble, bus.frame_tick} !== {exp_sel, exp_nib, exp_tick})
        $display("FAIL rst_after e=%0d: got %b/%h/%b want %b/%h/%b", e, bus.digit_sel, bus.nibble,
                 bus.frame_tick, exp_sel, exp_nib, exp_tick);
      else passed++;
    end
  endtask

  task automatic test_random();
    int low_run = 0;
    int high_run;
    rst = 1'b1; bus.load = 1'b0; bus.digit_en = 4'hF;
    step();
    rst = 1'b0;
    high_run = 1;
    for (int i = 0; i < 1500; i++) begin
      bus.load     = ($urandom % 12 == 0);
      bus.value_in = 16'($urandom);
      if ((cur_q >= S || cur_q < 0) && ($urandom % 4 == 0)) bus.digit_en = 4'($urandom);
      step();
      total++;
      if ({bus.digit_sel, bus.nibble, bus.frame_tick} !== {exp_sel, exp_nib, exp_tick})
        $display("FAIL random e=%0d: got %b/%h/%b want %b/%h/%b", e, bus.digit_sel, bus.nibble,
                 bus.frame_tick, exp_sel, exp_nib, exp_tick);
      else passed++;
      total++;
      if ($countones(~bus.digit_sel) > 1) $display("FAIL one_cold: got %b want <=1 low", bus.digit_sel);
      else passed++;
      if (bus.digit_sel !== 4'b1111) begin
        if (high_run > 0) begin
          total++;
          if (high_run < G) $display("FAIL gap_len: got %0d want >=%0d", high_run, G); else passed++;
        end
        high_run = 0; low_run++;
      end else begin
        if (low_run > 0) begin
          total++;
          if (low_run != S) $display("FAIL lit_len: got %0d want %0d", low_run, S); else passed++;
        end
        low_run = 0; high_run++;
      end
    end
    bus.load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_midframe();
    test_commit_collision();
    test_digit_en();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
